core_exec_operand_stage: RTL and testbench
==========================================

CORE_EXEC_OPERAND_STAGE -- requirements
Module: core_exec_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/data width in bits.
REQ-002 SHALL have parameter NUM_FWD, default 2, number of forwarding sources; index 0 is the youngest and has the highest priority.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream has an operation.
REQ-006 SHALL have port in_ready  output  1  stage accepts the operation this cycle.
REQ-007 SHALL have port exec_src  input  core_pkg::exec_src_e  operand source select, one of SRC_RR, SRC_RI, SRC_PI, SRC_ZI.
REQ-008 SHALL have ports rs1, rs2  input  5 each  source register indices.
REQ-009 SHALL have ports reg_a_value, reg_b_value, imm_val, pc  input  XLEN each  register-file values, immediate, PC.
REQ-010 SHALL have ports fwd_valid  input  NUM_FWD, fwd_busy  input  NUM_FWD, fwd_rd  input  5*NUM_FWD, fwd_data  input  XLEN*NUM_FWD  per-source write-back info; busy means the destination result is not yet available.
REQ-011 SHALL have port flush  input  1  kill the held operation.
REQ-012 SHALL have ports out_valid  output  1, out_ready  input  1  downstream handshake.
REQ-013 SHALL have ports src_a, src_b  output  XLEN each  registered operands.

Function
REQ-014 SHALL resolve operand A as: reg A for SRC_RR/SRC_RI; pc for SRC_PI; zero for SRC_ZI.
REQ-015 SHALL resolve operand B as: reg B for SRC_RR; imm_val for all other selects.
REQ-016 SHALL resolve reg A (reg B) as fwd_data[i] for the lowest i with fwd_valid[i]=1 and fwd_rd[i]=rs1 (rs2); otherwise reg_a_value (reg_b_value).
REQ-017 SHALL never forward for index 0; x0 always resolves to the register-file value.
REQ-018 SHALL raise a hazard when the highest-priority matching source for a used register operand has fwd_busy=1; an operand is used when its slot is not taken by pc, zero or imm.
REQ-019 SHALL drive in_ready = !hazard && (!out_valid || out_ready); in_ready depends on in_valid only through the hazard logic.
REQ-020 SHALL capture the resolved operands and set out_valid=1 on the cycle after an edge where in_valid && in_ready; latency is 1 cycle.
REQ-021 SHALL clear out_valid on out_valid && out_ready when no new capture occurs; a simultaneous capture keeps out_valid=1 (back-to-back throughput of 1 per cycle).
REQ-022 SHALL hold src_a, src_b and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL, on flush, clear out_valid next cycle and suppress any capture that same cycle; flush has priority over capture.
REQ-024 SHALL leave src_a and src_b unchanged when no capture occurs.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set out_valid=0, src_a=0 and src_b=0; reset has priority over flush and capture.
REQ-026 SHALL accept nothing on a cycle where rst=1, regardless of in_ready; a reset mid-operation discards the held operation.

Configuration
REQ-027 SHALL implement forwarding and the hazard logic only when macro CORE_EXEC_FWD_EN is defined.
REQ-028 SHALL, without CORE_EXEC_FWD_EN, ignore fwd_* inputs, use reg_a_value/reg_b_value directly, and drive in_ready = !out_valid || out_ready; ports are unchanged.

Verification
REQ-029 SHALL cover: SRC_PI, pc=0x0000_1000, imm=0x10, out_ready=1 -> next cycle out_valid=1, src_a=0x1000, src_b=0x10.
REQ-030 SHALL cover: SRC_RR, rs1=5, fwd0={valid,rd=5,data=0xAAAA_0000}, fwd1={valid,rd=5,data=0xBBBB_0000} -> src_a=0xAAAA_0000 (priority to index 0).
REQ-031 SHALL cover: rs1=0, fwd0={valid,rd=0,data=0xFFFF_FFFF}, reg_a_value=0 -> src_a=0.
REQ-032 SHALL cover: SRC_RR, rs2=7, fwd0={valid,busy,rd=7} -> in_ready=0 until busy drops; one capture follows; SRC_ZI with the same fwd state -> no stall.
REQ-033 SHALL cover: out_valid=1, out_ready=0 for 3 cycles -> src_a/src_b constant, in_ready=0; then flush and in_valid together -> out_valid=0, no capture.
REQ-034 SHALL cover: rst asserted while out_valid=1 -> next cycle out_valid=0, src_a=src_b=0.

Source files
------------

// File: rtl/core_exec_operand_stage.sv
// Execute operand stage: selects/forwards operands A and B and registers them behind a valid/ready skid-free register.
// Optional macro CORE_EXEC_FWD_EN enables write-back forwarding and busy-source hazard stalls.
package core_pkg;
    typedef enum logic [1:0] {
        SRC_RR = 2'd0,
        SRC_RI = 2'd1,
        SRC_PI = 2'd2,
        SRC_ZI = 2'd3
    } exec_src_e;
endpackage

module core_exec_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  core_pkg::exec_src_e           exec_src,
    input  logic [4:0]                    rs1,
    input  logic [4:0]                    rs2,
    input  logic [XLEN-1:0]               reg_a_value,
    input  logic [XLEN-1:0]               reg_b_value,
    input  logic [XLEN-1:0]               imm_val,
    input  logic [XLEN-1:0]               pc,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD-1:0]            fwd_busy,
    input  logic [NUM_FWD-1:0][4:0]       fwd_rd,
    input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               src_a,
    output logic [XLEN-1:0]               src_b
);
    import core_pkg::*;

    logic [XLEN-1:0] reg_a, reg_b, opnd_a, opnd_b;
    logic            hazard, capture;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] src_a_q, src_a_d, src_b_q, src_b_d;

`ifdef CORE_EXEC_FWD_EN
    logic busy_a, busy_b, use_a, use_b;

    // Walk from oldest to youngest so the lowest matching index wins; x0 never forwards.
    always_comb begin
        reg_a  = reg_a_value;
        reg_b  = reg_b_value;
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = NUM_FWD-1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i] == rs1) && (rs1 != 5'd0)) begin
                reg_a  = fwd_data[i];
                busy_a = fwd_busy[i];
            end
            if (fwd_valid[i] && (fwd_rd[i] == rs2) && (rs2 != 5'd0)) begin
                reg_b  = fwd_data[i];
                busy_b = fwd_busy[i];
            end
        end
    end

    assign use_a  = (exec_src == SRC_RR) || (exec_src == SRC_RI);
    assign use_b  = (exec_src == SRC_RR);
    assign hazard = (use_a && busy_a) || (use_b && busy_b);
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_busy, fwd_rd, fwd_data, rs1, rs2};
    assign reg_a      = reg_a_value;
    assign reg_b      = reg_b_value;
    assign hazard     = 1'b0;
`endif

    always_comb begin
        opnd_a = reg_a;
        opnd_b = imm_val;
        case (exec_src)
            SRC_RR:  opnd_b = reg_b;
            SRC_PI:  opnd_a = pc;
            SRC_ZI:  opnd_a = '0;
            default: ;
        endcase
    end

    assign in_ready = !hazard && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        if (flush)
            valid_d = 1'b0;
        else if (capture)
            valid_d = 1'b1;
        else if (out_ready)
            valid_d = 1'b0;
        if (capture) begin
            src_a_d = opnd_a;
            src_b_d = opnd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            src_a_q <= '0;
            src_b_q <= '0;
        end else begin
            valid_q <= valid_d;
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
        end
    end

    assign out_valid = valid_q;
    assign src_a     = src_a_q;
    assign src_b     = src_b_q;
endmodule

// File: tb/tb_core_exec_operand_stage.sv
// Directed bench for core_exec_operand_stage; expectations follow CORE_EXEC_FWD_EN when it is defined.
module tb_core_exec_operand_stage;
    import core_pkg::*;

    logic             clk = 1'b0;
    logic             rst, in_valid, in_ready, flush, out_valid, out_ready;
    exec_src_e        exec_src;
    logic [4:0]       rs1, rs2;
    logic [31:0]      reg_a_value, reg_b_value, imm_val, pc, src_a, src_b;
    logic [1:0]       fwd_valid, fwd_busy;
    logic [1:0][4:0]  fwd_rd;
    logic [1:0][31:0] fwd_data;

    int errors = 0;
    int checks = 0;

    core_exec_operand_stage #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exec_src(exec_src), .rs1(rs1), .rs2(rs2),
        .reg_a_value(reg_a_value), .reg_b_value(reg_b_value), .imm_val(imm_val), .pc(pc),
        .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .src_a(src_a), .src_b(src_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        exec_src = SRC_RR; rs1 = '0; rs2 = '0;
        reg_a_value = '0; reg_b_value = '0; imm_val = '0; pc = '0;
        fwd_valid = '0; fwd_busy = '0; fwd_rd = '0; fwd_data = '0;
        step(); step();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_src_a", src_a, 32'd0);
        check("reset_src_b", src_b, 32'd0);
        rst = 1'b0;

        // PC + immediate
        exec_src = SRC_PI; pc = 32'h0000_1000; imm_val = 32'h10; out_ready = 1'b1; in_valid = 1'b1;
        #1 check("pi_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("pi_out_valid", {31'd0, out_valid}, 32'd1);
        check("pi_src_a", src_a, 32'h0000_1000);
        check("pi_src_b", src_b, 32'h10);

        // Forward priority, back-to-back with previous capture
        exec_src = SRC_RR; rs1 = 5'd5; rs2 = 5'd6;
        reg_a_value = 32'h1111; reg_b_value = 32'h2222;
        fwd_valid = 2'b11; fwd_rd[0] = 5'd5; fwd_rd[1] = 5'd5;
        fwd_data[0] = 32'hAAAA_0000; fwd_data[1] = 32'hBBBB_0000;
        step();
        check("prio_out_valid", {31'd0, out_valid}, 32'd1);
`ifdef CORE_EXEC_FWD_EN
        check("prio_src_a", src_a, 32'hAAAA_0000);
`else
        check("prio_src_a", src_a, 32'h1111);
`endif
        check("prio_src_b", src_b, 32'h2222);

        // x0 never forwards
        exec_src = SRC_RI; rs1 = 5'd0; reg_a_value = 32'h0; imm_val = 32'h33;
        fwd_valid = 2'b01; fwd_rd[0] = 5'd0; fwd_data[0] = 32'hFFFF_FFFF;
        step();
        check("x0_src_a", src_a, 32'h0);
        check("x0_src_b", src_b, 32'h33);

        // Busy source on rs2 stalls RR
        exec_src = SRC_RR; rs1 = 5'd1; rs2 = 5'd7; reg_a_value = 32'h44; reg_b_value = 32'h2222;
        fwd_valid = 2'b01; fwd_busy = 2'b01; fwd_rd[0] = 5'd7; fwd_data[0] = 32'h7777;
`ifdef CORE_EXEC_FWD_EN
        #1 check("haz_in_ready0", {31'd0, in_ready}, 32'd0);
        step();
        check("haz_drain", {31'd0, out_valid}, 32'd0);
        check("haz_in_ready1", {31'd0, in_ready}, 32'd0);
        check("haz_hold_a", src_a, 32'h0);
        step();
        check("haz_in_ready2", {31'd0, in_ready}, 32'd0);
        fwd_busy = 2'b00;
        #1 check("haz_release", {31'd0, in_ready}, 32'd1);
        step();
        check("haz_src_b", src_b, 32'h7777);
`else
        #1 check("haz_in_ready0", {31'd0, in_ready}, 32'd1);
        step();
        check("haz_src_b", src_b, 32'h2222);
`endif
        check("haz_src_a", src_a, 32'h44);
        check("haz_out_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("haz_one_capture", {31'd0, out_valid}, 32'd0);

        // Same busy state, ZI does not use rs2
        fwd_busy = 2'b01; exec_src = SRC_ZI; imm_val = 32'h55;
        #1 check("zi_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("zi_src_a", src_a, 32'h0);
        check("zi_src_b", src_b, 32'h55);

        // Backpressure hold for 3 cycles
        fwd_valid = 2'b00; fwd_busy = 2'b00; out_ready = 1'b0;
        exec_src = SRC_PI; pc = 32'h9999; imm_val = 32'h66; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_src_a", src_a, 32'h0);
            check("bp_src_b", src_b, 32'h55);
        end

        // Flush with an acceptable input: no capture
        flush = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_src_a", src_a, 32'h0);
        check("flush_src_b", src_b, 32'h55);

        // Reset while holding
        out_ready = 1'b0; exec_src = SRC_PI; pc = 32'h1234; imm_val = 32'h5678; in_valid = 1'b1;
        step();
        check("pre_rst_src_a", src_a, 32'h1234);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; out_ready = 1'b1;
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_src_a", src_a, 32'h0);
        check("rst_src_b", src_b, 32'h0);
        step();
        check("rst_no_accept", {31'd0, out_valid}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
